// File: rtl/gesture_frame_rx.sv
// Gesture frame receiver: hunts for 3-byte frames (A5, code, A5^code) and writes good codes to a FIFO.
// Build macro GESTURE_DEDUP_EN: a good frame repeating the last written code is dropped silently.
module gesture_frame_rx #(
  parameter int MAX_CODE       = 10,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       fifo_full,
  output logic [7:0] fifo_wr_data,
  output logic       fifo_wr_en,
  output logic [7:0] frame_err_cnt,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam logic [7:0]       SYNC  = 8'hA5;
  localparam logic [7:0]       MAX_C = 8'(MAX_CODE);
  localparam int               CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, CODE, CHECK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]       code_p0;
  logic             frame_good, frame_bad;
  logic             code_ok, check_ok, dup;
  logic             wr_go, drop_go;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign code_ok  = (code_p0 != 8'd0) && (code_p0 <= MAX_C);
  assign check_ok = (rx_data == (SYNC ^ code_p0));
  assign busy     = (state != HUNT);

`ifdef GESTURE_DEDUP_EN
  logic [7:0] last_code;
  assign dup = (code_p0 == last_code);
`else
  assign dup = 1'b0;
`endif

  assign wr_go   = frame_good && !dup && !fifo_full;
  assign drop_go = frame_good && !dup &&  fifo_full;

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      HUNT: begin
        to_cnt_nxt = '0;
        if (rx_valid && rx_data == SYNC) state_nxt = CODE;
      end
      CODE: begin
        if (rx_valid) begin
          // A repeated sync byte is a resync: stay here with a fresh timeout.
          to_cnt_nxt = '0;
          if (rx_data != SYNC) state_nxt = CHECK;
        end else if (to_cnt == TERM) begin
          to_cnt_nxt = '0;
          state_nxt  = HUNT;
          frame_bad  = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          to_cnt_nxt = '0;
          state_nxt  = HUNT;
          if (check_ok && code_ok) frame_good = 1'b1;
          else                     frame_bad  = 1'b1;
        end else if (to_cnt == TERM) begin
          to_cnt_nxt = '0;
          state_nxt  = HUNT;
          frame_bad  = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt  = HUNT;
        to_cnt_nxt = '0;
      end
    endcase
  end

  // Stage p0: code byte capture (datapath, no reset needed).
  always_ff @(posedge clk) begin
    if (state == CODE && rx_valid && rx_data != SYNC) code_p0 <= rx_data;
  end

  // Frame verdict is registered into the FIFO strobe and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HUNT;
      to_cnt        <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= 8'h00;
      frame_err_cnt <= 8'h00;
      drop_cnt      <= 8'h00;
`ifdef GESTURE_DEDUP_EN
      last_code     <= 8'h00;
`endif
    end else begin
      state      <= state_nxt;
      to_cnt     <= to_cnt_nxt;
      fifo_wr_en <= wr_go;
      if (wr_go) begin
        fifo_wr_data <= code_p0;
`ifdef GESTURE_DEDUP_EN
        last_code    <= code_p0;
`endif
      end
      if (frame_bad) frame_err_cnt <= sat_inc(frame_err_cnt);
      if (drop_go)   drop_cnt      <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_gesture_frame_rx.sv
// Scoreboard bench for gesture_frame_rx: frame-level reference model feeds expected writes and status to a negedge monitor.
module tb_gesture_frame_rx;

  localparam int         TO   = 64;
  localparam int         MAXC = 10;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef GESTURE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] fifo_wr_data;
  logic       fifo_wr_en;
  logic [7:0] frame_err_cnt;
  logic [7:0] drop_cnt;
  logic       busy;

  gesture_frame_rx #(.MAX_CODE(MAXC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_full(fifo_full), .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .frame_err_cnt(frame_err_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [7:0] data; } wr_t;
  typedef struct { int idx; string name; logic [7:0] err; logic [7:0] drop; logic busy; } cc_t;

  wr_t  exp_q[$];
  cc_t  cc_q[$];
  int   neg_cnt = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  // Reference model: frame-level view of the byte stream.
  logic [7:0] m_buf[$];
  int         m_idle = 0;
  logic [7:0] m_err = 0, m_drop = 0, m_wr_data = 0, m_last = 0;
  logic       m_busy = 0;

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'd255) ? 8'd255 : v + 8'd1;
  endfunction

  task automatic judge(input logic [7:0] code, input logic [7:0] chk, input bit full);
    wr_t e;
    if (chk == (SYNC ^ code) && code >= 1 && code <= MAXC) begin
      if (DEDUP && code == m_last) begin
      end else if (full) begin
        m_drop = sat(m_drop);
      end else begin
        e.idx = neg_cnt; e.data = code;
        exp_q.push_back(e);
        m_wr_data = code; m_last = code;
      end
    end else begin
      m_err = sat(m_err);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit full);
    if (m_buf.size() == 0) begin
      if (v && d == SYNC) begin m_buf.push_back(d); m_idle = 0; end
    end else if (v) begin
      m_idle = 0;
      if (m_buf.size() == 1) begin
        if (d != SYNC) m_buf.push_back(d);
      end else begin
        judge(m_buf[1], d, full);
        m_buf.delete();
      end
    end else if (m_idle == TO - 1) begin
      m_err = sat(m_err); m_buf.delete(); m_idle = 0;
    end else begin
      m_idle++;
    end
    m_busy = (m_buf.size() != 0);
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit full);
    rx_valid = v; rx_data = d; fifo_full = full;
    @(posedge clk);
    model_step(v, d, full);
    #1;
    rx_valid = 1'b0; fifo_full = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0;
    @(posedge clk);
    m_buf.delete(); m_idle = 0; m_err = 0; m_drop = 0; m_wr_data = 0; m_last = 0; m_busy = 0;
    #1 reset = 1'b0;
  endtask

  task automatic frame(input logic [7:0] code, input logic [7:0] chk, input bit full);
    drive(1'b1, SYNC, full); drive(1'b1, code, full); drive(1'b1, chk, full);
  endtask

  task automatic expect_const(input string name, input logic [7:0] err, input logic [7:0] drop, input logic b);
    cc_t c;
    c.idx = neg_cnt; c.name = name; c.err = err; c.drop = drop; c.busy = b;
    cc_q.push_back(c);
  endtask

  // Monitor: all comparisons happen on the falling edge.
  wr_t         wr_e;
  cc_t         cc_e;
  logic [24:0] act_s, exp_s;
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_spurious: got write of %02h at cycle %0d, required no write", fifo_wr_data, neg_cnt);
      end else begin
        wr_e = exp_q.pop_front();
        if (wr_e.idx != neg_cnt || wr_e.data !== fifo_wr_data) begin
          n_fail++;
          $display("FAIL wr_data: got %02h at cycle %0d, required %02h at cycle %0d",
                   fifo_wr_data, neg_cnt, wr_e.data, wr_e.idx);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].idx <= neg_cnt) begin
      wr_e = exp_q.pop_front();
      n_vec++; n_fail++;
      $display("FAIL wr_missing: got no write at cycle %0d, required %02h", neg_cnt, wr_e.data);
    end
    act_s = {busy, frame_err_cnt, drop_cnt, fifo_wr_data};
    exp_s = {m_busy, m_err, m_drop, m_wr_data};
    n_vec++;
    if (act_s !== exp_s) begin
      n_fail++;
      $display("FAIL status: got busy/err/drop/data %h, required %h at cycle %0d", act_s, exp_s, neg_cnt);
    end
    if (cc_q.size() != 0 && cc_q[0].idx == neg_cnt) begin
      cc_e = cc_q.pop_front();
      n_vec++;
      if (busy !== cc_e.busy || frame_err_cnt !== cc_e.err || drop_cnt !== cc_e.drop) begin
        n_fail++;
        $display("FAIL %s: got busy=%b err=%0d drop=%0d, required busy=%b err=%0d drop=%0d", cc_e.name,
                 busy, frame_err_cnt, drop_cnt, cc_e.busy, cc_e.err, cc_e.drop);
      end
    end
    neg_cnt++;
  end

  initial begin
    logic [7:0] code, chk;
    int k;
    do_reset();
    expect_const("reset_state", 8'd0, 8'd0, 1'b0);
    idle(2);

    frame(8'h03, 8'hA6, 1'b0);
    idle(2);
    expect_const("good_frame_counts", 8'd0, 8'd0, 1'b0);
    frame(8'h03, 8'h00, 1'b0);
    expect_const("bad_check", 8'd1, 8'd0, 1'b0);
    frame(8'h0B, 8'hAE, 1'b0);
    expect_const("code_over_max", 8'd2, 8'd0, 1'b0);

    do_reset();
    drive(1'b1, SYNC, 1'b0);
    idle(TO - 1);
    expect_const("before_timeout", 8'd0, 8'd0, 1'b1);
    idle(1);
    expect_const("timeout", 8'd1, 8'd0, 1'b0);
    drive(1'b1, SYNC, 1'b0);
    idle(TO - 1);
    drive(1'b1, 8'h03, 1'b0);
    expect_const("terminal_byte_wins", 8'd1, 8'd0, 1'b1);
    drive(1'b1, 8'hA6, 1'b0);
    idle(2);

    do_reset();
    frame(8'h01, 8'hA4, 1'b1);
    expect_const("drop_on_full", 8'd0, 8'd1, 1'b0);
    drive(1'b1, SYNC, 1'b0);
    frame(8'h02, 8'hA7, 1'b0);
    idle(1);
    expect_const("resync", 8'd0, 8'd1, 1'b0);
    drive(1'b1, SYNC, 1'b0); drive(1'b1, 8'h02, 1'b0);
    do_reset();
    expect_const("reset_mid_frame", 8'd0, 8'd0, 1'b0);
    idle(2);

    frame(8'h04, 8'hA1, 1'b0);
    frame(8'h04, 8'hA1, 1'b0);
    idle(3);

    for (int i = 0; i < 300; i++) frame(8'h00, 8'hA5, 1'b0);
    expect_const("err_saturate", 8'd255, 8'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      code = 8'((i % MAXC) + 1);
      frame(code, SYNC ^ code, 1'b1);
    end
    expect_const("drop_saturate", 8'd0, 8'd255, 1'b0);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 11);
      code = 8'($urandom_range(0, 12));
      chk = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (SYNC ^ code);
      if (k < 8) begin
        drive(1'b1, SYNC, 1'($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive(1'b1, code, 1'($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive(1'b1, chk, 1'($urandom_range(0, 3) == 0));
      end else if (k == 8) begin
        drive(1'b1, 8'($urandom), 1'b0);
      end else if (k == 9) begin
        drive(1'b1, SYNC, 1'b0);
        idle($urandom_range(TO - 2, TO + 2));
      end else if (k == 10) begin
        if ($urandom_range(0, 3) == 0) do_reset();
        else drive(1'b1, SYNC, 1'b0);
      end else begin
        idle($urandom_range(0, 4));
      end
    end
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
